// File: rtl/rf_wb_if.sv
// rf_wb_if: write-back bus between the EXU/LSU write-back stage and the
// register-file write arbiter.
//   req0_*   : requester 0 (ALU/EXU result) valid/ready/addr/data
//   req1_*   : requester 1 (LSU load result) valid/ready/addr/data
//   rsv_*    : issue-stage destination reservation (scoreboard set)
//   rf_*     : registered register-file write port
// Modports: master = write-back side / register file, slave = arbiter.
interface rf_wb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  rsv_valid;
  logic [ADDR_WIDTH-1:0] rsv_addr;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output rsv_valid, rsv_addr,
    input  req0_ready, req1_ready,
    input  rf_wen, rf_waddr, rf_wdata
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  rsv_valid, rsv_addr,
    output req0_ready, req1_ready,
    output rf_wen, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter sharing the single register-file write
// port between requester 0 (EXU) and requester 1 (LSU). The winning write is
// registered and presented on rf_wen/rf_waddr/rf_wdata one cycle after accept.
// Writes to x0 (low address bits zero) are accepted but never enable rf_wen.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : rf_wb_if.slave (requests, reservations, rf write port)
//   busy       : per-register write-outstanding flags (bit 0 always 0)
//   last_grant : index of the most recently accepted requester
//
// Optional feature: define RF_WB_SCOREBOARD_EN to build the per-register
// scoreboard. Without it busy is tied to zero and rsv_* is ignored.
module rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NREG       = 2**(ADDR_WIDTH-1)
) (
  input  logic            clk,
  input  logic            rst_n,
  rf_wb_if.slave          bus,
  output logic [NREG-1:0] busy,
  output logic            last_grant
);
  // The upper address bit is carried to the register file but never used
  // for indexing (x0 detection or scoreboard).
  localparam int IDX_W = ADDR_WIDTH - 1;

  logic                  last_grant_reg;
  logic                  rf_wen_reg;
  logic [ADDR_WIDTH-1:0] rf_waddr_reg;
  logic [DATA_WIDTH-1:0] rf_wdata_reg;

  logic                  gnt0;
  logic                  gnt1;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic [IDX_W-1:0]      win_idx;

  // Grant depends only on valids and last_grant, never on a ready output.
  // On contention the requester that did not win last time is chosen.
  always_comb begin
    gnt0     = bus.req0_valid && (!bus.req1_valid || last_grant_reg);
    gnt1     = bus.req1_valid && (!bus.req0_valid || !last_grant_reg);
    accept   = gnt0 || gnt1;
    win_addr = gnt1 ? bus.req1_addr : bus.req0_addr;
    win_data = gnt1 ? bus.req1_data : bus.req0_data;
  end

  assign win_idx = win_addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // last_grant=1 so requester 0 wins the first contention.
      last_grant_reg <= 1'b1;
      rf_wen_reg     <= 1'b0;
      rf_waddr_reg   <= '0;
      rf_wdata_reg   <= '0;
    end else begin
      if (accept) begin
        last_grant_reg <= gnt1;
        rf_waddr_reg   <= win_addr;
        rf_wdata_reg   <= win_data;
      end
      rf_wen_reg <= accept && (win_idx != '0);
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rf_wen     = rf_wen_reg;
  assign bus.rf_waddr   = rf_waddr_reg;
  assign bus.rf_wdata   = rf_wdata_reg;
  assign last_grant     = last_grant_reg;

`ifdef RF_WB_SCOREBOARD_EN
  logic [IDX_W-1:0] rsv_idx;
  wire              unused_rsv_hi = bus.rsv_addr[ADDR_WIDTH-1];

  assign rsv_idx = bus.rsv_addr[IDX_W-1:0];
  assign busy[0] = 1'b0;

  // One flag per register. A reservation in the same cycle as the clearing
  // write wins, since it belongs to a newer instruction.
  for (genvar gi = 1; gi < NREG; gi++) begin : g_sb
    logic busy_bit_reg;
    logic set_hit;
    logic clr_hit;

    assign set_hit = bus.rsv_valid && (rsv_idx == IDX_W'(gi));
    assign clr_hit = accept && (win_idx == IDX_W'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy_bit_reg <= 1'b0;
      end else if (set_hit) begin
        busy_bit_reg <= 1'b1;
      end else if (clr_hit) begin
        busy_bit_reg <= 1'b0;
      end
    end

    assign busy[gi] = busy_bit_reg;
  end
`else
  wire unused_rsv = &{1'b0, bus.rsv_valid, bus.rsv_addr};

  assign busy = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: table-driven directed vectors, reset corner cases and a
// randomized run, all checked against a behavioural model of the arbiter.
module tb_rf_wb_arbiter;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 16;
`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic [NREG-1:0] busy;
  logic            last_grant;

  rf_wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREG(NREG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .last_grant (last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model state.
  int           m_last;
  bit           m_wen;
  int           m_waddr;
  longint       m_wdata;
  bit           m_busy [NREG];
  int           last_g;
  logic         seen_r0;
  logic         seen_r1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [NREG-1:0] model_busy();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    m_last  = 1;
    m_wen   = 0;
    m_waddr = 0;
    m_wdata = 0;
    for (int i = 0; i < NREG; i++) m_busy[i] = 0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic do_cycle(input string tag);
    int g;
    int a;
    int idx;
    longint d;
    #1;
    if (bus.req0_valid && bus.req1_valid) g = 1 - m_last;
    else if (bus.req0_valid)              g = 0;
    else if (bus.req1_valid)              g = 1;
    else                                  g = -1;
    seen_r0 = bus.req0_ready;
    seen_r1 = bus.req1_ready;
    chk({tag, ".req0_ready"}, 64'(bus.req0_ready), 64'(g == 0));
    chk({tag, ".req1_ready"}, 64'(bus.req1_ready), 64'(g == 1));
    @(posedge clk);
    if (g >= 0) begin
      a       = (g == 1) ? int'(bus.req1_addr) : int'(bus.req0_addr);
      d       = (g == 1) ? longint'(bus.req1_data) : longint'(bus.req0_data);
      idx     = a % NREG;
      m_last  = g;
      m_waddr = a;
      m_wdata = d;
      m_wen   = (idx != 0);
      m_busy[idx] = 0;
    end else begin
      m_wen = 0;
    end
    if (SB && bus.rsv_valid && (int'(bus.rsv_addr) % NREG) != 0)
      m_busy[int'(bus.rsv_addr) % NREG] = 1;
    @(negedge clk);
    chk({tag, ".rf_wen"},     64'(bus.rf_wen),   64'(m_wen));
    chk({tag, ".rf_waddr"},   64'(bus.rf_waddr), 64'(m_waddr));
    chk({tag, ".rf_wdata"},   64'(bus.rf_wdata), 64'(m_wdata));
    chk({tag, ".busy"},       64'(busy),         64'(model_busy()));
    chk({tag, ".last_grant"}, 64'(last_grant),   64'(m_last));
    last_g = g;
  endtask

  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic rv, input logic [AW-1:0] ra);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
    bus.rsv_valid  = rv; bus.rsv_addr  = ra;
  endtask

  typedef struct {
    logic            v0;
    logic [AW-1:0]   a0;
    logic [DW-1:0]   d0;
    logic            v1;
    logic [AW-1:0]   a1;
    logic [DW-1:0]   d1;
    logic            rv;
    logic [AW-1:0]   ra;
    logic            er0;
    logic            er1;
    logic            ewen;
    logic [AW-1:0]   ewaddr;
    logic [DW-1:0]   ewdata;
    logic [NREG-1:0] ebusy;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic rv, input logic [AW-1:0] ra,
                              input logic er0, input logic er1, input logic ewen,
                              input logic [AW-1:0] ewaddr, input logic [DW-1:0] ewdata,
                              input logic [NREG-1:0] ebusy);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.rv = rv; v.ra = ra; v.er0 = er0; v.er1 = er1; v.ewen = ewen;
    v.ewaddr = ewaddr; v.ewdata = ewdata; v.ebusy = ebusy;
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    logic [NREG-1:0] sb_mask;
    sb_mask = SB ? '1 : '0;

    // Expected outputs are those seen after the edge that consumes the inputs.
    tbl[0]  = mk(0, 0, 0,  1, 5, 32'hDEADBEEF, 0, 0,  0, 1, 1, 5, 32'hDEADBEEF, 16'h0000);
    tbl[1]  = mk(0, 0, 0,  0, 0, 0,            0, 0,  0, 0, 0, 5, 32'hDEADBEEF, 16'h0000);
    tbl[2]  = mk(1, 3, 32'h33, 1, 4, 32'h44,   0, 0,  1, 0, 1, 3, 32'h33,       16'h0000);
    tbl[3]  = mk(1, 3, 32'h33, 1, 4, 32'h44,   0, 0,  0, 1, 1, 4, 32'h44,       16'h0000);
    tbl[4]  = mk(1, 3, 32'h33, 1, 4, 32'h44,   0, 0,  1, 0, 1, 3, 32'h33,       16'h0000);
    tbl[5]  = mk(1, 3, 32'h33, 1, 4, 32'h44,   0, 0,  0, 1, 1, 4, 32'h44,       16'h0000);
    tbl[6]  = mk(1, 0, 32'h1234, 0, 0, 0,      0, 0,  1, 0, 0, 0, 32'h1234,     16'h0000);
    tbl[7]  = mk(0, 0, 0,  0, 0, 0,            1, 7,  0, 0, 0, 0, 32'h1234,     16'h0080);
    tbl[8]  = mk(1, 7, 32'h77, 0, 0, 0,        0, 0,  1, 0, 1, 7, 32'h77,       16'h0000);
    tbl[9]  = mk(0, 0, 0,  1, 7, 32'h71,       1, 7,  0, 1, 1, 7, 32'h71,       16'h0080);
    tbl[10] = mk(0, 0, 0,  0, 0, 0,            1, 0,  0, 0, 0, 7, 32'h71,       16'h0080);
    tbl[11] = mk(1, 5'h17, 32'hA5, 0, 0, 0,    0, 0,  1, 0, 1, 5'h17, 32'hA5,   16'h0000);
    tbl[12] = mk(0, 0, 0,  0, 0, 0,            1, 3,  0, 0, 0, 5'h17, 32'hA5,   16'h0008);
    tbl[13] = mk(0, 0, 0,  1, 5'h13, 32'h1313, 0, 0,  0, 1, 1, 5'h13, 32'h1313, 16'h0000);

    // Asynchronous reset, asserted away from any clock edge.
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("por.rf_wen",     64'(bus.rf_wen),   64'd0);
    chk("por.busy",       64'(busy),         64'd0);
    chk("por.last_grant", 64'(last_grant),   64'd1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, tbl[i].rv, tbl[i].ra);
      do_cycle($sformatf("vec%0d", i));
      $display("vec%0d r0=%0d r1=%0d wen=%0d waddr=0x%0h wdata=0x%0h busy=0x%0h",
               i, seen_r0, seen_r1, bus.rf_wen, bus.rf_waddr, bus.rf_wdata, busy);
      chk($sformatf("tbl%0d.ready0", i), 64'(seen_r0),      64'(tbl[i].er0));
      chk($sformatf("tbl%0d.ready1", i), 64'(seen_r1),      64'(tbl[i].er1));
      chk($sformatf("tbl%0d.rf_wen", i), 64'(bus.rf_wen),   64'(tbl[i].ewen));
      chk($sformatf("tbl%0d.waddr", i),  64'(bus.rf_waddr), 64'(tbl[i].ewaddr));
      chk($sformatf("tbl%0d.wdata", i),  64'(bus.rf_wdata), 64'(tbl[i].ewdata));
      chk($sformatf("tbl%0d.busy", i),   64'(busy),         64'(tbl[i].ebusy & sb_mask));
    end

    // Mid-cycle reset while a write is on the port and a register is busy.
    drive(1, 9, 32'h9999, 0, 0, 0, 1, 5);
    do_cycle("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.rf_wen",     64'(bus.rf_wen),   64'd0);
    chk("midrst.rf_waddr",   64'(bus.rf_waddr), 64'd0);
    chk("midrst.rf_wdata",   64'(bus.rf_wdata), 64'd0);
    chk("midrst.busy",       64'(busy),         64'd0);
    chk("midrst.last_grant", 64'(last_grant),   64'd1);
    model_reset();
    @(negedge clk);
    chk("inrst.rf_wen", 64'(bus.rf_wen), 64'd0);
    rst_n = 1'b1;
    drive(1, 10, 32'hA0A0, 1, 11, 32'hB1B1, 0, 0);
    do_cycle("post_rst");
    $display("post_rst r0=%0d r1=%0d waddr=0x%0h", seen_r0, seen_r1, bus.rf_waddr);
    chk("post_rst.first_grant_r0", 64'(seen_r0), 64'd1);
    chk("post_rst.first_grant_r1", 64'(seen_r1), 64'd0);

    // Randomized traffic; requesters hold addr/data until accepted.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    last_g = -1;
    for (int i = 0; i < 400; i++) begin
      if (!bus.req0_valid || last_g == 0) begin
        bus.req0_valid = ($urandom_range(0, 3) != 0);
        bus.req0_addr  = AW'($urandom_range(0, 31));
        bus.req0_data  = $urandom;
      end
      if (!bus.req1_valid || last_g == 1) begin
        bus.req1_valid = ($urandom_range(0, 3) != 0);
        bus.req1_addr  = AW'($urandom_range(0, 31));
        bus.req1_data  = $urandom;
      end
      bus.rsv_valid = ($urandom_range(0, 2) == 0);
      bus.rsv_addr  = AW'($urandom_range(0, 31));
      do_cycle($sformatf("rnd%0d", i));
      $display("rnd%0d grant=%0d wen=%0d waddr=0x%0h busy=0x%0h",
               i, last_g, bus.rf_wen, bus.rf_waddr, busy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
